// File: rtl/gtech_aoi_pipe.sv
// Elastic pipeline of per-channel AOI/OAI cells with valid/ready flow
// control, bubble collapse and a saturating completed-transfer counter.
module gtech_aoi_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNTW   = 8
) (
    input  logic             CP,
    input  logic             CD,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    input  logic             IV,
    output logic             IR,
    output logic [WIDTH-1:0] Z,
    output logic             OV,
    input  logic             OR,
    output logic [CNTW-1:0]  OCNT
);

    logic [WIDTH-1:0]             f;
    logic [STAGES-1:0]            v;
    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [STAGES-1:0]            up_v;
    logic [STAGES-1:0][WIDTH-1:0] up_d;
    logic [STAGES:0]              rdy;
    logic [CNTW-1:0]              cnt;

    always_comb begin
        f = '0;
        unique case (MODE)
            2'b00: f = ~((A & B) | (C & D));
            2'b01: f = ~((A & B) | ~(C | D));
            2'b10: f = ~((A | B) & (C | D));
            2'b11: f = (A & B) | ~(C | D);
        endcase
    end

    // A stage may take new data if it or any later stage has room.
    always_comb begin
        logic r;
        r           = OR;
        rdy[STAGES] = OR;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = ~v[k] | r;
            rdy[k] = r;
        end
    end

    always_comb begin
        up_v[0] = IV;
        up_d[0] = f;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = data[k-1];
        end
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            v    <= '0;
            data <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k])
                        data[k] <= up_d[k];
                end
            end
        end
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD)
            cnt <= '0;
        else if (OV && OR && (cnt != {CNTW{1'b1}}))
            cnt <= cnt + CNTW'(1);
    end

    assign IR   = rdy[0];
    assign Z    = data[STAGES-1];
    assign OV   = v[STAGES-1];
    assign OCNT = cnt;

endmodule

// File: tb/tb_gtech_aoi_pipe.sv
// Bench for gtech_aoi_pipe: queue-based flow model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_gtech_aoi_pipe;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 4;

    logic          CP = 1'b0;
    logic          CD = 1'b0;
    logic [W-1:0]  A = '0, B = '0, C = '0, D = '0;
    logic [1:0]    MODE = '0;
    logic          IV = 1'b0;
    logic          IR;
    logic [W-1:0]  Z;
    logic          OV;
    logic          OR = 1'b0;
    logic [CW-1:0] OCNT;

    int checks = 0;
    int errors = 0;

    gtech_aoi_pipe #(.WIDTH(W), .STAGES(S), .CNTW(CW)) dut (
        .CP(CP), .CD(CD), .A(A), .B(B), .C(C), .D(D), .MODE(MODE),
        .IV(IV), .IR(IR), .Z(Z), .OV(OV), .OR(OR), .OCNT(OCNT)
    );

    always #5 CP = ~CP;

    function automatic logic [W-1:0] fn(input logic [1:0] m,
                                        input logic [W-1:0] a, b, c, d);
        case (m)
            2'd0:    return ~((a & b) | (c & d));
            2'd1:    return ~((a & b) | ~(c | d));
            2'd2:    return ~((a | b) & (c | d));
            default: return (a & b) | ~(c | d);
        endcase
    endfunction

    // Model: ordered list of words, each with its position in the pipe.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } ent_t;

    ent_t q[$];
    int   mcnt = 0;

    always @(posedge CP or negedge CD) begin
        if (!CD) begin
            q.delete();
            mcnt = 0;
        end else begin
            bit acc;
            bit out;
            int lim;
            acc = IV && ((q.size() < S) || OR);
            out = (q.size() > 0) && (q[0].pos == S - 1) && OR;
            if (out) begin
                void'(q.pop_front());
                if (mcnt < (1 << CW) - 1) mcnt++;
            end
            lim = S;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].pos + 1 < lim) q[i].pos++;
                lim = q[i].pos;
            end
            if (acc) q.push_back('{d: fn(MODE, A, B, C, D), pos: 0});
        end
    end

    always @(negedge CP) begin
        bit eov;
        eov = (q.size() > 0) && (q[0].pos == S - 1);
        checks++;
        if (OV !== eov) begin
            errors++;
            $display("FAIL model_ov got %0b exp %0b t=%0t", OV, eov, $time);
        end
        checks++;
        if (IR !== ((q.size() < S) || OR || !CD)) begin
            errors++;
            $display("FAIL model_ir got %0b t=%0t", IR, $time);
        end
        checks++;
        if (OCNT !== CW'(mcnt)) begin
            errors++;
            $display("FAIL model_ocnt got %0d exp %0d t=%0t", OCNT, mcnt, $time);
        end
        if (eov) begin
            checks++;
            if (Z !== q[0].d) begin
                errors++;
                $display("FAIL model_z got %b exp %b t=%0t", Z, q[0].d, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drv(input logic iv, input logic orr, input logic [1:0] m,
                       input logic [W-1:0] a, b, c, d);
        IV = iv; OR = orr; MODE = m;
        A = a; B = b; C = c; D = d;
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_z", Z, 0);
        chk("rst_ov", OV, 0);
        chk("rst_ocnt", OCNT, 0);
        chk("rst_ir", IR, 1);
        tick();
        CD = 1'b1;

        // Four functions back to back
        drv(1, 1, 0, 4'b1100, 4'b1010, 4'b0011, 4'b0101);
        tick();
        chk("lat_ov0", OV, 0);
        MODE = 2'd1;
        tick();
        chk("seq_ov1", OV, 1);
        chk("seq_z0", Z, 4'b0110);
        MODE = 2'd2;
        tick();
        chk("seq_z1", Z, 4'b0111);
        MODE = 2'd3;
        tick();
        chk("seq_z2", Z, 4'b1001);
        IV = 1'b0;
        tick();
        chk("seq_z3", Z, 4'b1000);
        chk("seq_ov", OV, 1);
        tick();
        chk("seq_end_ov", OV, 0);
        chk("seq_ocnt", OCNT, 4);

        // Stall with a full pipe, then drain
        drv(1, 0, 3, 4'b0110, 4'b1111, 4'b1111, 4'b0000);
        tick();
        chk("bub_ov", OV, 0);
        chk("bub_ir", IR, 1);
        MODE = 2'd0;
        tick();
        chk("full_ov", OV, 1);
        chk("full_z", Z, 4'b0110);
        chk("full_ir", IR, 0);
        MODE = 2'd2;
        repeat (5) tick();
        chk("hold_ov", OV, 1);
        chk("hold_z", Z, 4'b0110);
        chk("hold_ir", IR, 0);
        chk("hold_ocnt", OCNT, 4);
        OR = 1'b1;
        tick();
        chk("drain_z1", Z, 4'b1001);
        chk("drain_c1", OCNT, 5);
        IV = 1'b0;
        tick();
        chk("drain_z2", Z, 4'b0000);
        chk("drain_c2", OCNT, 6);
        tick();
        chk("drain_ov", OV, 0);
        chk("drain_ocnt", OCNT, 7);

        // Saturating counter
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
            tick();
        end
        IV = 1'b0;
        repeat (3) tick();
        chk("sat_ocnt", OCNT, 15);

        // Reset with words in flight
        drv(1, 0, 0, 4'b1100, 4'b1010, 4'b0011, 4'b0101);
        repeat (2) tick();
        chk("pre_rst_ov", OV, 1);
        CD = 1'b0;
        #1;
        chk("mid_rst_z", Z, 0);
        chk("mid_rst_ov", OV, 0);
        chk("mid_rst_ocnt", OCNT, 0);
        chk("mid_rst_ir", IR, 1);
        tick();
        chk("rst_discard", OV, 0);
        CD = 1'b1;
        OR = 1'b1;
        tick();
        chk("post_ov0", OV, 0);
        IV = 1'b0;
        tick();
        chk("post_ov1", OV, 1);
        chk("post_z", Z, 4'b0110);
        tick();
        chk("post_ocnt", OCNT, 1);

        // Random flow control against the model
        for (int i = 0; i < 150; i++) begin
            drv(1'($urandom), 1'($urandom_range(3) != 0),
                2'($urandom_range(3)), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
            tick();
        end
        drv(0, 1, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("final_ov", OV, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gtech_aoi_pipe.md
GTECH_AOI_PIPE -- requirements
Module: gtech_aoi_pipe

Interface
REQ-001 Parameter WIDTH, default 4, meaning number of independent bit channels; legal 1..64.
REQ-002 Parameter STAGES, default 2, meaning pipeline depth in register stages; legal 1..8.
REQ-003 Parameter CNTW, default 8, meaning width of the completed-transfer counter; legal 2..32.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: CP and CD.
REQ-005 Port list, clock and reset first:
 CP  in  1  clock, rising edge active
 CD  in  1  asynchronous active-low reset (clear)
 A  in  WIDTH  operand A, per channel
 B  in  WIDTH  operand B, per channel
 C  in  WIDTH  operand C, per channel
 D  in  WIDTH  operand D, per channel
 MODE  in  2  function select, sampled with the data
 IV  in  1  input valid
 IR  out  1  input ready
 Z  out  WIDTH  registered result of the last stage
 OV  out  1  output valid
 OR  in  1  output ready (downstream accept)
 OCNT  out  CNTW  count of completed output transfers

Function
REQ-006 Per channel i, MODE 00 SHALL compute ~((A&B)|(C&D)) (AOI22).
REQ-007 MODE 01 SHALL compute ~((A&B)|~(C|D)) (AOI2N2).
REQ-008 MODE 10 SHALL compute ~((A|B)&(C|D)) (OAI22).
REQ-009 MODE 11 SHALL compute (A&B)|~(C|D) (AO2N2, non-inverted).
REQ-010 Function SHALL be evaluated combinationally on inputs; result captured into stage 0 on the input transfer (IV&IR at rising CP); MODE only affects the word accepted in that cycle.
REQ-011 Each stage k (0..STAGES-1) SHALL hold a WIDTH-bit data register and a valid bit v[k]; Z = data[STAGES-1], OV = v[STAGES-1].
REQ-012 Ready chain: rdy[STAGES] = OR; rdy[k] = ~v[k] | rdy[k+1]; IR = rdy[0]; purely combinational, no registered ready.
REQ-013 Stage k SHALL load from stage k-1 (or input for k=0) when rdy[k]=1; v[k] takes the upstream valid (v[k-1], or IV for k=0); data register loads only when upstream valid=1.
REQ-014 With OR held 1, latency SHALL be exactly STAGES cycles from input transfer to OV=1, throughput one word per cycle.
REQ-015 Bubbles SHALL collapse: an empty stage accepts new data even while a later stage stalls.
REQ-016 When OV=1 and OR=0, Z and OV SHALL hold stable until the transfer; no word dropped or duplicated.
REQ-017 Simultaneous output transfer and input transfer on a full pipe SHALL be accepted in the same cycle (full throughput under OR=1).
REQ-018 IV=1 with IR=0: no transfer; upstream holds data; block takes no action.
REQ-019 OCNT SHALL increment by 1 on each output transfer (OV&OR) and saturate at 2^CNTW-1 (no wrap).
REQ-020 Data order SHALL be strictly FIFO; words never reordered.

Reset
REQ-021 CD=0 SHALL asynchronously clear all v[k], all data registers, and OCNT to 0; Z=0, OV=0, OCNT=0 immediately.
REQ-022 During reset IR SHALL equal 1 (all stages empty); input transfers attempted while CD=0 SHALL be discarded.
REQ-023 Reset mid-operation SHALL discard all in-flight words; first post-reset word emerges after STAGES cycles.
REQ-024 Release of CD SHALL be treated as synchronous to CP by the integrator; first capture on the first rising CP with CD=1.

Verification (WIDTH=4, STAGES=2, CNTW=4)
REQ-025 A=1100,B=1010,C=0011,D=0101, IV=1, OR=1, MODE 00/01/10/11 on consecutive cycles -> Z sequence 0110,0111,1001,1000 with OV=1 starting 2 cycles after first transfer, one word per cycle.
REQ-026 Fill with 3 words then OR=0 for 5 cycles -> IR=0 after 2 words held (pipe full), Z/OV stable, OCNT unchanged; OR=1 -> words drain in order, OCNT +3.
REQ-027 Single word into empty pipe with OR=0 -> word advances to stage 1 (bubble collapse), OV=1 after 2 cycles; second word accepted next cycle, IR=0 afterwards.
REQ-028 20 back-to-back transfers with OR=1 -> OCNT counts 1..15 then holds 15.
REQ-029 CD pulsed low while pipe holds 2 words and OV=1 -> Z=0000, OV=0, OCNT=0 immediately, IR=1; next word appears 2 cycles after release.
